// File: rtl/player_hit_judge.sv
// player_hit_judge: player-vs-enemy-bullet collision and damage judge.
// Latency: positions sampled at edge k give hit/bullet_kill/health at edge k+1
// (overlap register, then FSM). No backpressure: kills are one-shot pulses and
// the bullet pool must drop eb_en within 2 cycles.
//
// Optional feature macro: PLAYER_HIT_INVULN_EN
//   defined   -> a non-fatal hit opens a frame-counted invulnerability window
//   undefined -> no INVULN state; invuln tied low; frame_tick ignored
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, init_health  begin a life with the given health (start wins over all)
//   frame_tick          one pulse per video frame (invulnerability timer)
//   p_x, p_y, p_en      player top-left corner and presence
//   eb_x, eb_y, eb_en   packed enemy bullet corners and per-channel enables
//   health              current health
//   hit                 one-cycle pulse per damaging hit
//   bullet_kill         one-cycle per-channel clear request to the bullet pool
//   invuln              high while invulnerable
//   boom                high while dead

module player_hit_judge #(
    parameter int N_BULLETS     = 4,
    parameter int COORD_W       = 10,
    parameter int HP_W          = 4,
    parameter int PLAYER_W      = 40,
    parameter int PLAYER_H      = 40,
    parameter int BULLET_W      = 10,
    parameter int BULLET_H      = 10,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [HP_W-1:0]                init_health,
    input  logic                           frame_tick,
    input  logic [COORD_W-1:0]             p_x,
    input  logic [COORD_W-1:0]             p_y,
    input  logic                           p_en,
    input  logic [N_BULLETS*COORD_W-1:0]   eb_x,
    input  logic [N_BULLETS*COORD_W-1:0]   eb_y,
    input  logic [N_BULLETS-1:0]           eb_en,
    output logic [HP_W-1:0]                health,
    output logic                           hit,
    output logic [N_BULLETS-1:0]           bullet_kill,
    output logic                           invuln,
    output logic                           boom
);

    // Hitbox extents widened by one bit so corner + size never wraps.
    localparam logic [COORD_W:0] PW = (COORD_W+1)'(PLAYER_W);
    localparam logic [COORD_W:0] PH = (COORD_W+1)'(PLAYER_H);
    localparam logic [COORD_W:0] BW = (COORD_W+1)'(BULLET_W);
    localparam logic [COORD_W:0] BH = (COORD_W+1)'(BULLET_H);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIVE  = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t                 state;
    logic [N_BULLETS-1:0]   ov_comb;
    logic [N_BULLETS-1:0]   ov;
    logic [HP_W-1:0]        health_dec;

    // ------------------------------------------------------------------
    // Stage 1: per-channel axis-aligned box overlap, unsigned, no wrap.
    // ------------------------------------------------------------------
    logic [COORD_W:0] px_w, py_w;
    assign px_w = {1'b0, p_x};
    assign py_w = {1'b0, p_y};

    for (genvar i = 0; i < N_BULLETS; i++) begin : g_ov
        logic [COORD_W:0] bx_w, by_w;
        assign bx_w = {1'b0, eb_x[i*COORD_W +: COORD_W]};
        assign by_w = {1'b0, eb_y[i*COORD_W +: COORD_W]};
        assign ov_comb[i] = eb_en[i] & p_en
                          & ((bx_w + BW) > px_w) & ((px_w + PW) > bx_w)
                          & ((by_w + BH) > py_w) & ((py_w + PH) > by_w);
    end

    // The overlap captured alongside start belongs to the previous life,
    // so it is dropped rather than judged against the freshly loaded health.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov <= '0;
        end else if (start) begin
            ov <= '0;
        end else begin
            ov <= ov_comb;
        end
    end

    // Saturating decrement: health can never go below zero.
    assign health_dec = (health == '0) ? '0 : health - 1'b1;

`ifdef PLAYER_HIT_INVULN_EN
    localparam int IC_W = $clog2(INVULN_FRAMES + 1);
    logic [IC_W-1:0] inv_cnt;
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
    assign invuln = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 2: life/damage FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            health      <= '0;
            hit         <= 1'b0;
            bullet_kill <= '0;
            boom        <= 1'b0;
`ifdef PLAYER_HIT_INVULN_EN
            invuln      <= 1'b0;
            inv_cnt     <= '0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            hit         <= 1'b0;
            bullet_kill <= '0;

            if (start) begin
                health <= init_health;
`ifdef PLAYER_HIT_INVULN_EN
                invuln  <= 1'b0;
                inv_cnt <= '0;
`endif
                if (init_health == '0) begin
                    state <= DEAD;
                    boom  <= 1'b1;
                end else begin
                    state <= ALIVE;
                    boom  <= 1'b0;
                end
            end else begin
                case (state)
                    ALIVE: begin
                        // Any number of simultaneous overlaps cost one health;
                        // all overlapping bullets are consumed.
                        if (|ov) begin
                            hit         <= 1'b1;
                            bullet_kill <= ov;
                            health      <= health_dec;
                            if (health_dec == '0) begin
                                state <= DEAD;
                                boom  <= 1'b1;
                            end else begin
`ifdef PLAYER_HIT_INVULN_EN
                                state   <= INVULN;
                                invuln  <= 1'b1;
                                inv_cnt <= IC_W'(INVULN_FRAMES);
`else
                                state <= ALIVE;
`endif
                            end
                        end
                    end
`ifdef PLAYER_HIT_INVULN_EN
                    INVULN: begin
                        // Bullets touching an invulnerable player are still
                        // consumed, but do no damage.
                        bullet_kill <= ov;
                        if (frame_tick) begin
                            if (inv_cnt <= IC_W'(1)) begin
                                state   <= ALIVE;
                                invuln  <= 1'b0;
                                inv_cnt <= '0;
                            end else begin
                                inv_cnt <= inv_cnt - 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        // IDLE and DEAD wait for start; overlaps are ignored.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_hit_judge.sv
// Scoreboard bench for player_hit_judge: directed vectors push expected
// outputs tagged with the cycle they are due; a monitor compares them.
// Runs in either build of the invulnerability feature.

module tb_player_hit_judge;

    localparam int NB = 4;
    localparam int CW = 10;
    localparam int HW = 4;
`ifdef PLAYER_HIT_INVULN_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [HW-1:0]     init_health = '0;
    logic              frame_tick = 1'b0;
    logic [CW-1:0]     p_x = CW'(95);
    logic [CW-1:0]     p_y = CW'(95);
    logic              p_en = 1'b1;
    logic [NB*CW-1:0]  eb_x = '0;
    logic [NB*CW-1:0]  eb_y = '0;
    logic [NB-1:0]     eb_en = '0;
    logic [HW-1:0]     health;
    logic              hit;
    logic [NB-1:0]     bullet_kill;
    logic              invuln;
    logic              boom;

    player_hit_judge #(
        .N_BULLETS(NB), .COORD_W(CW), .HP_W(HW),
        .PLAYER_W(40), .PLAYER_H(40), .BULLET_W(10), .BULLET_H(10),
        .INVULN_FRAMES(60)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .init_health(init_health),
        .frame_tick(frame_tick), .p_x(p_x), .p_y(p_y), .p_en(p_en),
        .eb_x(eb_x), .eb_y(eb_y), .eb_en(eb_en),
        .health(health), .hit(hit), .bullet_kill(bullet_kill),
        .invuln(invuln), .boom(boom)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        string         name;
        logic [HW-1:0] h;
        logic          ht;
        logic [NB-1:0] k;
        logic          iv;
        logic          bm;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    event check_now;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due in the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or check_now);
            while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (e.tag < cyc) begin
                    miscompares++;
                    $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.tag, cyc);
                end else if ({health, hit, bullet_kill, invuln, boom} !== {e.h, e.ht, e.k, e.iv, e.bm}) begin
                    miscompares++;
                    $display("FAIL %s: got health=%0d hit=%b kill=%b invuln=%b boom=%b, expected health=%0d hit=%b kill=%b invuln=%b boom=%b",
                             e.name, health, hit, bullet_kill, invuln, boom, e.h, e.ht, e.k, e.iv, e.bm);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input int d, input string nm, input int h, input logic ht,
                              input logic [NB-1:0] k, input logic iv, input logic bm);
        exp_t e;
        e.tag = cyc + d; e.name = nm; e.h = HW'(h); e.ht = ht; e.k = k; e.iv = iv; e.bm = bm;
        sbq.push_back(e);
    endtask

    task automatic place(input int i, input int x, input int y);
        eb_x[i*CW +: CW] = CW'(x);
        eb_y[i*CW +: CW] = CW'(y);
    endtask

    task automatic start_life(input string nm, input int h0);
        expect_out(1, nm, h0, 1'b0, '0, 1'b0, h0 == 0);
        start = 1'b1;
        init_health = HW'(h0);
        tick();
        start = 1'b0;
    endtask

    // Bullets present for exactly one sample; outputs due two edges later,
    // then the pulses must be gone on the following edge.
    task automatic shoot(input string nm, input logic [NB-1:0] m, input int h, input logic ht,
                         input logic [NB-1:0] k, input logic iv, input logic bm);
        expect_out(2, nm, h, ht, k, iv, bm);
        expect_out(3, {nm, "_after"}, h, 1'b0, '0, iv, bm);
        eb_en = m;
        tick();
        eb_en = '0;
        tick();
        tick();
    endtask

    initial begin
        // Reset state, with overlapping stimulus present.
        place(0, 100, 100);
        eb_en = 4'b0001;
        tick(); tick();
        expect_out(0, "reset", 0, 1'b0, '0, 1'b0, 1'b0);
        eb_en = '0;
        rst = 1'b0;
        tick();

        // First hit.
        start_life("start3", 3);
        shoot("first_hit", 4'b0001, 2, 1'b1, 4'b0001, INV, 1'b0);

        // Two bullets in one cycle cost one health, both killed.
        start_life("restart3", 3);
        place(1, 110, 120);
        place(3, 130, 130);
        shoot("double", 4'b1010, 2, 1'b1, 4'b1010, INV, 1'b0);

`ifdef PLAYER_HIT_INVULN_EN
        place(2, 100, 100);
        shoot("inv_kill", 4'b0100, 2, 1'b0, 4'b0100, 1'b1, 1'b0);
        for (int n = 0; n < 59; n++) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
        end
        expect_out(0, "inv_59_ticks", 2, 1'b0, '0, 1'b1, 1'b0);
        frame_tick = 1'b1; tick(); frame_tick = 1'b0;
        expect_out(0, "inv_60_ticks", 2, 1'b0, '0, 1'b0, 1'b0);
        tick();
        shoot("post_inv_hit", 4'b0001, 1, 1'b1, 4'b0001, 1'b1, 1'b0);
`else
        // Without invulnerability a held bullet hits on consecutive cycles.
        place(2, 100, 100);
        expect_out(2, "rapid1", 1, 1'b1, 4'b0100, 1'b0, 1'b0);
        expect_out(3, "rapid2", 0, 1'b1, 4'b0100, 1'b0, 1'b1);
        expect_out(4, "rapid_after", 0, 1'b0, '0, 1'b0, 1'b1);
        eb_en = 4'b0100;
        tick(); tick();
        eb_en = '0;
        tick(); tick();
`endif

        // Hitbox edges and wide sums.
        start_life("edge_start", 3);
        place(0, 135, 100);
        shoot("x_right_out", 4'b0001, 3, 1'b0, '0, 1'b0, 1'b0);
        place(0, 134, 100);
        shoot("x_right_in", 4'b0001, 2, 1'b1, 4'b0001, INV, 1'b0);
        start_life("edge_start2", 3);
        place(0, 85, 100);
        shoot("x_left_out", 4'b0001, 3, 1'b0, '0, 1'b0, 1'b0);
        place(0, 86, 100);
        shoot("x_left_in", 4'b0001, 2, 1'b1, 4'b0001, INV, 1'b0);
        start_life("edge_start3", 3);
        place(0, 100, 135);
        shoot("y_bottom_out", 4'b0001, 3, 1'b0, '0, 1'b0, 1'b0);
        p_x = CW'(1020);
        place(0, 5, 100);
        shoot("no_wrap", 4'b0001, 3, 1'b0, '0, 1'b0, 1'b0);
        place(0, 1015, 100);
        shoot("far_right_in", 4'b0001, 2, 1'b1, 4'b0001, INV, 1'b0);
        p_x = CW'(95);
        start_life("pen_start", 3);
        p_en = 1'b0;
        place(0, 100, 100);
        shoot("p_en_low", 4'b0001, 3, 1'b0, '0, 1'b0, 1'b0);
        p_en = 1'b1;

        // Fatal hit, dead state, revival.
        start_life("start1", 1);
        shoot("fatal", 4'b0001, 0, 1'b1, 4'b0001, 1'b0, 1'b1);
        shoot("dead_ignores", 4'b0001, 0, 1'b0, '0, 1'b0, 1'b1);
        start_life("revive5", 5);
        start_life("start0", 0);

        // Start together with an overlap: reload only.
        expect_out(1, "start_ov_load", 4, 1'b0, '0, 1'b0, 1'b0);
        expect_out(2, "start_ov_ignored", 4, 1'b0, '0, 1'b0, 1'b0);
        start = 1'b1;
        init_health = HW'(4);
        eb_en = 4'b0001;
        tick();
        start = 1'b0;
        eb_en = '0;
        tick(); tick();

        // Asynchronous reset while hit is high.
        expect_out(2, "pre_rst_hit", 3, 1'b1, 4'b0001, INV, 1'b0);
        eb_en = 4'b0001;
        tick();
        eb_en = '0;
        tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        expect_out(0, "async_rst", 0, 1'b0, '0, 1'b0, 1'b0);
        -> check_now;
        tick(); tick();
        rst = 1'b0;
        tick();
        shoot("idle_ignores", 4'b0001, 0, 1'b0, '0, 1'b0, 1'b0);

        tick(); tick();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never checked (due cycle %0d)", e.name, e.tag);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
